alu_32: RTL and testbench

ALU_32 -- requirements
Module: alu_32

---
 rtl/alu_pkg.sv | 30 +++
 rtl/adder32.sv | 18 +
 rtl/comparator.sv | 13 +
 rtl/alu_32.sv | 95 +++++++++
 tb/tb_alu_32.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op-code constants and byte-lane helper for the 32-bit ALU.
package alu_pkg;

  localparam int unsigned ALU_W  = 32;
  localparam int unsigned ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_AND   = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_OR    = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_ADD   = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_XOR   = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_SUB   = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_SLT   = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_ADD4  = 4'd8;
  localparam logic [ALU_OPW-1:0] ALU_ADDS4 = 4'd9;

  // Four independent byte-lane adds; sat selects clamp-to-FF instead of wrap.
  function automatic logic [ALU_W-1:0] add4(input logic [ALU_W-1:0] a,
                                            input logic [ALU_W-1:0] b,
                                            input logic sat);
    logic [ALU_W-1:0] r;
    logic [8:0]       lane;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      lane = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
      r[8*i +: 8] = (sat && lane[8]) ? 8'hFF : lane[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit adder with carry-in; overflow flags a signed result whose sign
// disagrees with two like-signed inputs (b is already inverted for SUB).
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  // Full-width sum with carry-out and signed overflow.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    overflow    = (a[31] == b[31]) && (sum[31] != a[31]);
  end

endmodule

// File: rtl/comparator.sv
// Combinational 32-bit equality compare.
module comparator (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq
);

  // Equality, independent of op.
  always_comb begin
    eq = (a == b);
  end

endmodule

// File: rtl/alu_32.sv
// 32-bit ALU: combinational datapath followed by one output register stage.
module alu_32
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  op,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        carry,
  output logic        overflow,
  output logic        equal
);

  logic        is_sub;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        add_ovf;
  logic        eq;

  logic [31:0] result_d, result_q;
  logic        zero_d, zero_q;
  logic        carry_d, carry_q;
  logic        ovf_d, ovf_q;
  logic        equal_d, equal_q;

  // SLT shares the subtract path to get the overflow-corrected sign.
  assign is_sub = (op == ALU_SUB) || (op == ALU_SLT);
  assign add_b  = is_sub ? ~src_b : src_b;

  adder32 u_adder (
    .a        (src_a),
    .b        (add_b),
    .cin      (is_sub),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  comparator u_cmp (
    .a  (src_a),
    .b  (src_b),
    .eq (eq)
  );

  // Result mux and flags; undefined ops fall through to zero.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    unique case (op)
      ALU_AND:   result_d = src_a & src_b;
      ALU_OR:    result_d = src_a | src_b;
      ALU_XOR:   result_d = src_a ^ src_b;
      ALU_ADD, ALU_SUB: begin
        result_d = add_sum;
        carry_d  = add_cout;
        ovf_d    = add_ovf;
      end
      ALU_SLT:   result_d = {31'd0, add_sum[31] ^ add_ovf};
      ALU_ADD4:  result_d = add4(src_a, src_b, 1'b0);
      ALU_ADDS4: result_d = add4(src_a, src_b, 1'b1);
      default:   result_d = '0;
    endcase
    zero_d  = (result_d == '0);
    equal_d = eq;
  end

  // Single output register stage; reset wins over any sampled op.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      equal_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      equal_q  <= equal_d;
    end
  end

  assign alu_result = result_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign overflow   = ovf_q;
  assign equal      = equal_q;

endmodule

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32 with an expected-result queue.
module tb_alu_32;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_a, src_b;
  logic [3:0]  op;
  logic [31:0] alu_result;
  logic        zero, carry, overflow, equal;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];

  alu_32 dut (
    .clk        (clk),
    .reset      (reset),
    .src_a      (src_a),
    .src_b      (src_b),
    .op         (op),
    .alu_result (alu_result),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .equal      (equal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    logic [32:0] w;
    int     lane;
    e   = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    e.e = (a == b);
    case (o)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd3: e.res = a ^ b;
      4'd2: begin
        w = {1'b0, a} + {1'b0, b};
        e.res = w[31:0];
        e.c = w[32];
        s = sa + sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        e.res = a - b;
        e.c = (a >= b);
        s = sa - sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd8, 4'd9: begin
        for (int i = 0; i < 4; i++) begin
          lane = int'(a[8*i +: 8]) + int'(b[8*i +: 8]);
          if (o == 4'd9 && lane > 255) lane = 255;
          e.res[8*i +: 8] = 8'(lane);
        end
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Drive one op just after a rising edge, then advance past the next edge.
  task automatic step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    op = o; src_a = a; src_b = b;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t got, exp;
    reset = 1'b1; op = 4'd2; src_a = 32'd5; src_b = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    got = {alu_result, zero, carry, overflow, equal};
    exp = {32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_init got=%h want=%h", got, exp);
    end
    reset = 1'b0;
    // first op after deassert shows up one edge later
    step(4'd2, 32'd40, 32'd2, model(4'd2, 32'd40, 32'd2));
    got = {alu_result, zero, carry, overflow, equal};
    exp = exp_q.pop_front();
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL first_after_reset got=%h want=%h", got, exp);
    end
    // reset asserted during an ADD takes priority
    reset = 1'b1; op = 4'd2; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    reset = 1'b0;
    got = {alu_result, zero, carry, overflow, equal};
    exp = {32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_during_add got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_directed();
    vec_t v[$];
    exp_t got, exp;
    v = '{
      '{4'd2, 32'd37, 32'd10, 32'd47, 1'b0, 1'b0},
      '{4'd6, 32'd37, 32'd10, 32'd27, 1'b1, 1'b0},
      '{4'd0, 32'd37, 32'd10, 32'd0,  1'b0, 1'b0},
      '{4'd1, 32'd37, 32'd10, 32'd47, 1'b0, 1'b0},
      '{4'd3, 32'd37, 32'd10, 32'd47, 1'b0, 1'b0},
      '{4'd7, 32'd37, 32'd10, 32'd0,  1'b0, 1'b0},
      '{4'd7, 32'd50, 32'd60, 32'd1,  1'b0, 1'b0},
      '{4'd7, 32'hFFFF_FFF0, 32'd16, 32'd1, 1'b0, 1'b0},
      '{4'd6, 32'hFFFF_FFF0, 32'd16, 32'hFFFF_FFE0, 1'b1, 1'b0},
      '{4'd2, 32'hFFFF_FFFD, 32'd19, 32'd16, 1'b1, 1'b0},
      '{4'd2, 32'd1999999999, 32'd1999999999, 32'hEE6B_27FE, 1'b0, 1'b1},
      '{4'd7, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0},
      '{4'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0},
      '{4'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1},
      '{4'd8, 32'h30FF_02FF, 32'h06FF_01FF, 32'h36FE_03FE, 1'b0, 1'b0},
      '{4'd9, 32'h0000_00FF, 32'd1, 32'h0000_00FF, 1'b0, 1'b0},
      '{4'd9, 32'h0000_003F, 32'd3, 32'h0000_0042, 1'b0, 1'b0},
      '{4'd9, 32'h80FF_7F01, 32'h80FF_0101, 32'hFFFF_8002, 1'b0, 1'b0},
      '{4'd4, 32'd37, 32'd10, 32'd0, 1'b0, 1'b0}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b,
           '{res: v[i].res, z: (v[i].res == 32'd0), c: v[i].c, v: v[i].v, e: (v[i].a == v[i].b)});
      got = {alu_result, zero, carry, overflow, equal};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL directed[%0d] op=%0d got=%h want=%h", i, v[i].op, got, exp);
      end
    end
  endtask

  task automatic test_equal();
    logic [31:0] pa[5] = '{32'd7, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] pb[5] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'h1234_5679};
    logic [3:0]  po[5] = '{4'd2, 4'd0, 4'd12, 4'd9, 4'd6};
    logic        pe[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t e, got, exp;
    for (int i = 0; i < 5; i++) begin
      e = model(po[i], pa[i], pb[i]);
      e.e = pe[i];
      step(po[i], pa[i], pb[i], e);
      got = {alu_result, zero, carry, overflow, equal};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL equal[%0d] got=%h want=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_undefined();
    logic [3:0] undef_ops[8] = '{4'd4, 4'd5, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [31:0] a, b;
    exp_t got, exp;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      step(undef_ops[i], a, b, '{res: 32'd0, z: 1'b1, c: 1'b0, v: 1'b0, e: (a == b)});
      got = {alu_result, zero, carry, overflow, equal};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL undefined op=%0d got=%h want=%h", undef_ops[i], got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  o;
    logic [31:0] a, b;
    exp_t got, exp;
    for (int i = 0; i < 300; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = ~a + 32'd1;
        2: a = {1'b0, a[30:0]};
        default: ;
      endcase
      step(o, a, b, model(o, a, b));
      got = {alu_result, zero, carry, overflow, equal};
      exp = exp_q.pop_front();
      n_total++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, got, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; src_a = '0; src_b = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_equal();
    test_undefined();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
